// File: rtl/grain_pkg.sv
// Shared types, tap positions and feedback/output functions for the Grain v1 keystream generator.
package grain_pkg;

  localparam int KEY_W = 80;
  localparam int IV_W  = 64;
  localparam int REG_W = 80;

  typedef enum logic [1:0] {IDLE, LOAD, INIT, RUN} state_t;
  typedef logic [REG_W-1:0] reg_t;

  localparam int NS_TAPS [6]  = '{0, 13, 23, 38, 51, 62};
  localparam int NB_TAPS [11] = '{0, 9, 14, 21, 28, 33, 37, 45, 52, 60, 62};
  localparam int Z_TAPS  [7]  = '{1, 2, 4, 10, 31, 43, 56};
  localparam int H_X0 = 3;
  localparam int H_X1 = 25;
  localparam int H_X2 = 46;
  localparam int H_X3 = 64;
  localparam int H_X4 = 63;

  function automatic logic grain_ns(input reg_t s);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 6; i++) r ^= s[NS_TAPS[i]];
    return r;
  endfunction

  function automatic logic grain_nb(input reg_t b, input reg_t s);
    logic r;
    r = s[0];
    for (int i = 0; i < 11; i++) r ^= b[NB_TAPS[i]];
    r ^= (b[9] & b[15]) ^ (b[33] & b[37]) ^ (b[60] & b[63])
       ^ (b[21] & b[28] & b[33]) ^ (b[45] & b[52] & b[60])
       ^ (b[9] & b[28] & b[45] & b[63]) ^ (b[33] & b[37] & b[52] & b[60])
       ^ (b[15] & b[21] & b[60] & b[63]) ^ (b[37] & b[45] & b[52] & b[60] & b[63])
       ^ (b[9] & b[15] & b[21] & b[28] & b[33])
       ^ (b[21] & b[28] & b[33] & b[37] & b[45] & b[52]);
    return r;
  endfunction

  // h keeps the linear x1 and x4 terms of Grain v1; the published test vectors depend on them.
  function automatic logic grain_z(input reg_t b, input reg_t s);
    logic r, x0, x1, x2, x3, x4;
    x0 = s[H_X0];
    x1 = s[H_X1];
    x2 = s[H_X2];
    x3 = s[H_X3];
    x4 = b[H_X4];
    r = x1 ^ x4 ^ (x0 & x3) ^ (x2 & x3) ^ (x3 & x4) ^ (x0 & x1 & x2)
      ^ (x0 & x2 & x3) ^ (x0 & x2 & x4) ^ (x1 & x2 & x4) ^ (x2 & x3 & x4);
    for (int i = 0; i < 7; i++) r ^= b[Z_TAPS[i]];
    return r;
  endfunction

endpackage

// File: rtl/grain_keystream_gen_if.sv
// Key-management request and keystream valid/ready bundle of the Grain generator.
interface grain_keystream_gen_if #(
  parameter int WIDTH = 8
) ();
  import grain_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key;
  logic [IV_W-1:0]  iv;
  logic             busy;
  logic             ks_valid;
  logic             ks_ready;
  logic [WIDTH-1:0] ks_data;

  modport master (output start, key, iv, ks_ready, input busy, ks_valid, ks_data);
  modport slave  (input start, key, iv, ks_ready, output busy, ks_valid, ks_data);
endinterface

// File: rtl/grain_step.sv
// One combinational Grain v1 clock: shifts both registers and produces the output bit z.
module grain_step
  import grain_pkg::*;
(
  input  reg_t b,
  input  reg_t s,
  input  logic init_mode,
  output reg_t b_next,
  output reg_t s_next,
  output logic z
);

  logic nb;
  logic ns;

  // NOTE: every output is assigned on every path through always_comb, so no latch is inferred.
  always_comb begin
    z      = grain_z(b, s);
    nb     = grain_nb(b, s) ^ (init_mode & z);
    ns     = grain_ns(s) ^ (init_mode & z);
    b_next = {nb, b[REG_W-1:1]};
    s_next = {ns, s[REG_W-1:1]};
  end

endmodule

// File: rtl/grain_keystream_gen.sv
// Grain v1 keystream generator: key/IV load, INIT_ROUNDS feedback clocks, then WIDTH bits per
// accepted word over a valid/ready handshake.
module grain_keystream_gen
  import grain_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INIT_ROUNDS = 160
) (
  input logic                  clk,
  input logic                  rst,
  grain_keystream_gen_if.slave bus
);

  localparam int INIT_CLKS = INIT_ROUNDS / WIDTH;
  localparam int CNT_W     = $clog2(INIT_CLKS + 1);
  localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(INIT_CLKS - 1);

  state_t           state;
  reg_t             b_q;
  reg_t             s_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  logic             init_mode;
  logic [WIDTH-1:0] z_word;
  reg_t             b_adv;
  reg_t             s_adv;

  assign init_mode = (state == INIT);

  // Step k consumes the state left by step k-1; z of step k lands in bit k (bit 0 earliest).
  for (genvar k = 0; k < WIDTH; k++) begin : g_step
    reg_t b_in;
    reg_t s_in;
    reg_t b_out;
    reg_t s_out;
    if (k == 0) begin : g_head
      assign b_in = b_q;
      assign s_in = s_q;
    end else begin : g_link
      assign b_in = g_step[k-1].b_out;
      assign s_in = g_step[k-1].s_out;
    end
    grain_step u_step (
      .b        (b_in),
      .s        (s_in),
      .init_mode(init_mode),
      .b_next   (b_out),
      .s_next   (s_out),
      .z        (z_word[k])
    );
  end

  assign b_adv = g_step[WIDTH-1].b_out;
  assign s_adv = g_step[WIDTH-1].s_out;

  // NOTE: the cipher registers are ordinary flops rather than a memory, so they take the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every branch below reads the pre-edge register values.
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          b_q   <= bus.key;
          s_q   <= {{(REG_W - IV_W){1'b1}}, bus.iv};
          cnt_q <= '0;
          state <= INIT;
        end
        INIT: begin
          b_q   <= b_adv;
          s_q   <= s_adv;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_INIT) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.start) begin
            // A restart drops the pending word; the new stream begins from a fresh load.
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= LOAD;
          end else if (!valid_q || bus.ks_ready) begin
            b_q     <= b_adv;
            s_q     <= s_adv;
            data_q  <= z_word;
            valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ks_valid = valid_q;
  assign bus.ks_data  = data_q;

endmodule
